// File: rtl/sample_avg_pkg.sv
// Shared types and constants for the sample averager slice.
package sample_avg_pkg;

   localparam int unsigned Y_W            = 6;
   localparam int unsigned LOG2_N_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      HOLD
   } state_t;

endpackage

// File: rtl/sample_averager_if.sv
// Sample-in / average-out bundle; master is the upstream/downstream environment, slave is the averager.
interface sample_averager_if;
   import sample_avg_pkg::*;

   logic           y_is_valid;
   logic [Y_W-1:0] y;
   logic           out_ready;
   logic [Y_W-1:0] avg;
   logic           avg_valid;
   logic           busy;
   logic           overrun;

   modport master (
      output y_is_valid, y, out_ready,
      input  avg, avg_valid, busy, overrun
   );

   modport slave (
      input  y_is_valid, y, out_ready,
      output avg, avg_valid, busy, overrun
   );

endinterface

// File: rtl/sample_averager_avg_divider.sv
// Divides a full window sum by 2^LOG2_N; rounds half up when SAMPLE_AVERAGER_ROUND_EN is defined.
module avg_divider
   import sample_avg_pkg::*;
#(
   parameter int unsigned LOG2_N = LOG2_N_DEFAULT
) (
   input  logic [Y_W+LOG2_N-1:0] sum,
   output logic [Y_W-1:0]        avg
);

   localparam int unsigned SUM_W = Y_W + LOG2_N;

`ifdef SAMPLE_AVERAGER_ROUND_EN
   localparam logic [SUM_W-1:0] HALF = SUM_W'(1 << (LOG2_N - 1));

   // 63*N + N/2 < 64*N, so the biased sum never wraps
   logic [SUM_W-1:0] biased;

   always_comb begin
      biased = sum + HALF;
      avg    = biased[SUM_W-1:LOG2_N];
   end
`else
   always_comb begin
      avg = sum[SUM_W-1:LOG2_N];
   end
`endif

endmodule

// File: rtl/sample_averager.sv
// Windowed sample averager: accumulates 2^LOG2_N samples, holds the average until handshake.
// Optional build macro: SAMPLE_AVERAGER_ROUND_EN (round half up instead of truncating).
module sample_averager
   import sample_avg_pkg::*;
#(
   parameter int unsigned LOG2_N = LOG2_N_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   sample_averager_if.slave  bus
);

   localparam int unsigned SUM_W = Y_W + LOG2_N;
   localparam int unsigned CNT_W = LOG2_N + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG2_N) - 1);

   state_t           state, state_next;
   logic [SUM_W-1:0] sum, sum_next, sum_in;
   logic [CNT_W-1:0] count, count_next;
   logic [Y_W-1:0]   avg_r, avg_next, div_avg;
   logic             overrun_r, overrun_next;

   assign sum_in = sum + SUM_W'(bus.y);

   avg_divider #(.LOG2_N(LOG2_N)) u_div (
      .sum (sum_in),
      .avg (div_avg)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         sum       <= '0;
         count     <= '0;
         avg_r     <= '0;
         overrun_r <= 1'b0;
      end else begin
         state     <= state_next;
         sum       <= sum_next;
         count     <= count_next;
         avg_r     <= avg_next;
         overrun_r <= overrun_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.y_is_valid) state_next = ACC;
         ACC:  if (bus.y_is_valid && count == LAST) state_next = HOLD;
         HOLD: if (bus.out_ready) state_next = bus.y_is_valid ? ACC : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sum_next     = sum;
      count_next   = count;
      avg_next     = avg_r;
      overrun_next = overrun_r;
      case (state)
         IDLE, ACC: begin
            if (bus.y_is_valid) begin
               if (state == ACC && count == LAST) begin
                  avg_next   = div_avg;
                  sum_next   = '0;
                  count_next = '0;
               end else begin
                  sum_next   = sum_in;
                  count_next = count + 1'b1;
               end
            end
         end
         HOLD: begin
            // sum is already zero here, so a coincident sample starts the next window directly
            if (bus.out_ready) begin
               sum_next   = bus.y_is_valid ? SUM_W'(bus.y) : '0;
               count_next = bus.y_is_valid ? CNT_W'(1) : '0;
            end else if (bus.y_is_valid) begin
               overrun_next = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.avg       = avg_r;
      bus.avg_valid = (state == HOLD);
      bus.busy      = (state != IDLE);
      bus.overrun   = overrun_r;
   end

endmodule

// File: tb/tb_sample_averager.sv
// Scoreboard bench for sample_averager (LOG2_N=2), directed windows plus randomized traffic.
module tb_sample_averager;
   import sample_avg_pkg::*;

   localparam int unsigned L = 2;
   localparam int unsigned N = 1 << L;

   logic clk;
   logic rst;
   sample_averager_if sif ();

   sample_averager #(.LOG2_N(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   int tests;
   int fails;

   int unsigned win[$];
   int unsigned exp_q[$];
   bit          m_pending;
   bit          m_overrun;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned window_avg(input int unsigned s);
`ifdef SAMPLE_AVERAGER_ROUND_EN
      return (s + N / 2) / N;
`else
      return s / N;
`endif
   endfunction

   // Reference model: applied at each clock edge with the inputs present at that edge
   task automatic model_step(input bit yv, input int unsigned yval, input bit rdy);
      int unsigned s;
      if (m_pending && !rdy) begin
         if (yv) m_overrun = 1'b1;
      end else begin
         if (m_pending) m_pending = 1'b0;
         if (yv) begin
            win.push_back(yval);
            if (win.size() == N) begin
               s = 0;
               foreach (win[i]) s += win[i];
               exp_q.push_back(window_avg(s));
               win.delete();
               m_pending = 1'b1;
            end
         end
      end
   endtask

   task automatic cycle(input bit yv, input int unsigned yval, input bit rdy);
      sif.y_is_valid = yv;
      sif.y          = yval[Y_W-1:0];
      sif.out_ready  = rdy;
      @(posedge clk);
      if (rst) model_step(yv, yval, rdy);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      sif.y_is_valid = 1'b0;
      sif.out_ready  = 1'b0;
      #2;
      check("rst_avg", sif.avg, 0);
      check("rst_avg_valid", sif.avg_valid, 0);
      check("rst_busy", sif.busy, 0);
      check("rst_overrun", sif.overrun, 0);
      @(posedge clk);
      #1;
      win.delete();
      exp_q.delete();
      m_pending = 1'b0;
      m_overrun = 1'b0;
      rst = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         check("avg_valid", sif.avg_valid, m_pending);
         check("busy", sif.busy, (m_pending || win.size() != 0) ? 1 : 0);
         check("overrun", sif.overrun, m_overrun);
         if (sif.avg_valid && sif.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               check("avg", sif.avg, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      tests          = 0;
      fails          = 0;
      m_pending      = 1'b0;
      m_overrun      = 1'b0;
      rst            = 1'b0;
      sif.y_is_valid = 1'b0;
      sif.y          = '0;
      sif.out_ready  = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // basic average
      cycle(1, 10, 1); cycle(1, 20, 1); cycle(1, 30, 1); cycle(1, 40, 1);
      cycle(0, 0, 1);  cycle(0, 0, 1);

      // rounding and full scale
      cycle(1, 1, 1); cycle(1, 2, 1); cycle(1, 2, 1); cycle(1, 2, 1);
      cycle(0, 0, 1);
      for (int i = 0; i < 4; i++) cycle(1, 63, 1);
      cycle(0, 0, 1);

      // backpressure with a dropped sample
      for (int i = 0; i < 4; i++) cycle(1, 4, 0);
      cycle(1, 50, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0);
      cycle(0, 0, 1);
      for (int i = 0; i < 4; i++) cycle(1, 8, 1);
      cycle(0, 0, 1);

      // handshake coincident with first sample of the next window
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, 5, 0);
      cycle(0, 0, 0);
      cycle(1, 12, 1);
      for (int i = 0; i < 3; i++) cycle(1, 12, 1);
      cycle(0, 0, 1);

      // reset mid-window
      cycle(1, 60, 1); cycle(1, 60, 1);
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, 1, 1);
      cycle(0, 0, 1);

      // randomized traffic with one reset in the middle
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 63), $urandom_range(0, 2) != 0);
      end

      for (int i = 0; i < 3; i++) cycle(0, 0, 1);
      check("results_outstanding", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
